// File: rtl/wb_pkg.sv
// Shared types for the writeback/commit stage: load sizes, FSM states
// and the bypass history entry layout.
package wb_pkg;

  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10,
    LD_FULL = 2'b11
  } ld_size_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  // History fields are sized for the widest legal build
  localparam int HIST_ADDR_W = 8;
  localparam int HIST_DATA_W = 64;

  typedef struct packed {
    logic                   valid;
    logic [HIST_ADDR_W-1:0] addr;
    logic [HIST_DATA_W-1:0] data;
  } hist_t;

endpackage

// File: rtl/wb_load_align.sv
// Little-endian sub-word load extraction with sign/zero extension.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] data
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] MSB_MAX = IW'(DATA_W-1);

  logic [OFF_W-1:0]  sh_off;
  logic [IW-1:0]     msb;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] mask;
  logic              neg;

  always_comb begin
    sh_off = '0;
    msb    = MSB_MAX;
    unique case (1'b1)
      size == LD_BYTE: begin
        sh_off = off;
        msb    = IW'(7);
      end
      size == LD_HALF: begin
        sh_off = off & ~OFF_W'(1);
        msb    = IW'(15);
      end
      size == LD_WORD: begin
        sh_off = off & ~OFF_W'(3);
        msb    = IW'(31);
      end
      default: ;
    endcase
    sh   = rdata >> {sh_off, 3'b000};
    mask = {DATA_W{1'b1}} >> (MSB_MAX - msb);
    neg  = sgn & sh[msb];
    data = neg ? (sh | ~mask) : (sh & mask);
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage with late-load wait state and registered RF write.
// Optional bypass history enabled by defining WB_BYPASS_EN.
module wb_commit
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int HIST_DEPTH = 4,
  parameter int NUM_LOOKUP = 2,
  parameter int OFF_W      = $clog2(DATA_W/8)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_WB_valid,
  output logic                         o_WB_ready,
  input  logic                         i_WB_ctrl_RegWrite,
  input  logic                         i_WB_ctrl_Mem2Reg,
  input  logic [1:0]                   i_WB_ctrl_LdSize,
  input  logic                         i_WB_ctrl_LdSigned,
  input  logic [OFF_W-1:0]             i_WB_data_ByteOff,
  input  logic [ADDR_W-1:0]            i_WB_data_RegAddrW,
  input  logic [DATA_W-1:0]            i_WB_data_ALUData,
  input  logic                         i_WB_mem_rvalid,
  input  logic [DATA_W-1:0]            i_WB_mem_rdata,
  output logic                         o_WB_reg_RegWrite,
  output logic [ADDR_W-1:0]            o_WB_reg_RegAddrW,
  output logic [DATA_W-1:0]            o_WB_reg_RegDataW,
  input  logic [NUM_LOOKUP*ADDR_W-1:0] i_WB_byp_Addr,
  output logic [NUM_LOOKUP-1:0]        o_WB_byp_Hit,
  output logic [NUM_LOOKUP*DATA_W-1:0] o_WB_byp_Data
);

  wb_state_e state, state_nxt;

  logic              acc, commit, wr_nxt;
  logic              p_rw, p_sgn;
  logic [1:0]        p_size;
  logic [OFF_W-1:0]  p_off;
  logic [ADDR_W-1:0] p_addr;

  logic              c_rw, c_ld, c_sgn;
  logic [1:0]        c_size;
  logic [OFF_W-1:0]  c_off;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] ld_data, c_data;

  assign o_WB_ready = (state == IDLE);
  assign acc        = i_WB_valid && o_WB_ready;

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    c_rw      = i_WB_ctrl_RegWrite;
    c_ld      = i_WB_ctrl_Mem2Reg;
    c_size    = i_WB_ctrl_LdSize;
    c_sgn     = i_WB_ctrl_LdSigned;
    c_off     = i_WB_data_ByteOff;
    c_addr    = i_WB_data_RegAddrW;
    unique case (state)
      IDLE: begin
        if (acc) begin
          if (i_WB_ctrl_Mem2Reg && !i_WB_mem_rvalid) state_nxt = WAIT_MEM;
          else commit = 1'b1;
        end
      end
      WAIT_MEM: begin
        c_rw   = p_rw;
        c_ld   = 1'b1;
        c_size = p_size;
        c_sgn  = p_sgn;
        c_off  = p_off;
        c_addr = p_addr;
        if (i_WB_mem_rvalid) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  wb_load_align #(
    .DATA_W(DATA_W),
    .OFF_W (OFF_W)
  ) u_align (
    .rdata(i_WB_mem_rdata),
    .size (c_size),
    .sgn  (c_sgn),
    .off  (c_off),
    .data (ld_data)
  );

  assign c_data = c_ld ? ld_data : i_WB_data_ALUData;
  assign wr_nxt = commit && c_rw && (c_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      o_WB_reg_RegWrite <= 1'b0;
      o_WB_reg_RegAddrW <= '0;
      o_WB_reg_RegDataW <= '0;
      p_rw              <= 1'b0;
      p_size            <= '0;
      p_sgn             <= 1'b0;
      p_off             <= '0;
      p_addr            <= '0;
    end else begin
      state             <= state_nxt;
      o_WB_reg_RegWrite <= wr_nxt;
      if (commit) begin
        o_WB_reg_RegAddrW <= c_addr;
        o_WB_reg_RegDataW <= c_data;
      end
      if (acc) begin
        p_rw   <= i_WB_ctrl_RegWrite;
        p_size <= i_WB_ctrl_LdSize;
        p_sgn  <= i_WB_ctrl_LdSigned;
        p_off  <= i_WB_data_ByteOff;
        p_addr <= i_WB_data_RegAddrW;
      end
    end
  end

`ifdef WB_BYPASS_EN
  hist_t hist [HIST_DEPTH];
  logic  unused_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else if (wr_nxt) begin
      for (int i = HIST_DEPTH-1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= '{valid: 1'b1,
                   addr:  HIST_ADDR_W'(c_addr),
                   data:  HIST_DATA_W'(c_data)};
    end
  end

  // Scan oldest to newest so the newest match wins
  always_comb begin
    o_WB_byp_Hit  = '0;
    o_WB_byp_Data = '0;
    for (int p = 0; p < NUM_LOOKUP; p++) begin
      for (int i = HIST_DEPTH-1; i >= 0; i--) begin
        if (hist[i].valid
            && i_WB_byp_Addr[p*ADDR_W +: ADDR_W] != '0
            && hist[i].addr == HIST_ADDR_W'(i_WB_byp_Addr[p*ADDR_W +: ADDR_W])) begin
          o_WB_byp_Hit[p]                 = 1'b1;
          o_WB_byp_Data[p*DATA_W +: DATA_W] = DATA_W'(hist[i].data);
        end
      end
    end
  end

  always_comb begin
    unused_hist = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) unused_hist = unused_hist ^ (^hist[i]);
  end
`else
  logic unused_byp;

  assign unused_byp    = ^i_WB_byp_Addr;
  assign o_WB_byp_Hit  = '0;
  assign o_WB_byp_Data = '0;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_wb_commit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int HD = 4;
  localparam int NL = 2;
  localparam int OW = 2;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             valid, ready;
  logic             rw, m2r, sg;
  logic [1:0]       sz;
  logic [OW-1:0]    off;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    alu;
  logic             rvalid;
  logic [DW-1:0]    rdata;
  logic             o_wr;
  logic [AW-1:0]    o_addr;
  logic [DW-1:0]    o_data;
  logic [NL*AW-1:0] byp_addr;
  logic [NL-1:0]    byp_hit;
  logic [NL*DW-1:0] byp_data;

  wb_commit #(
    .DATA_W(DW), .ADDR_W(AW), .HIST_DEPTH(HD), .NUM_LOOKUP(NL)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_WB_valid        (valid),
    .o_WB_ready        (ready),
    .i_WB_ctrl_RegWrite(rw),
    .i_WB_ctrl_Mem2Reg (m2r),
    .i_WB_ctrl_LdSize  (sz),
    .i_WB_ctrl_LdSigned(sg),
    .i_WB_data_ByteOff (off),
    .i_WB_data_RegAddrW(addr),
    .i_WB_data_ALUData (alu),
    .i_WB_mem_rvalid   (rvalid),
    .i_WB_mem_rdata    (rdata),
    .o_WB_reg_RegWrite (o_wr),
    .o_WB_reg_RegAddrW (o_addr),
    .o_WB_reg_RegDataW (o_data),
    .i_WB_byp_Addr     (byp_addr),
    .o_WB_byp_Hit      (byp_hit),
    .o_WB_byp_Data     (byp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rw;
    logic          m2r;
    logic [1:0]    sz;
    logic          sg;
    logic [OW-1:0] off;
    logic [AW-1:0] addr;
    logic [DW-1:0] alu;
  } ins_t;

  typedef struct {
    ins_t          in;
    logic [DW-1:0] rd;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } hent_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic put(input ins_t x, input logic v, input logic rv, input logic [DW-1:0] rd);
    valid  = v;
    rw     = x.rw;
    m2r    = x.m2r;
    sz     = x.sz;
    sg     = x.sg;
    off    = x.off;
    addr   = x.addr;
    alu    = x.alu;
    rvalid = rv;
    rdata  = rd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic ins_t mk(input logic r, input logic m, input logic [1:0] s,
                              input logic g, input logic [OW-1:0] o,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
    ins_t x;
    x.rw = r; x.m2r = m; x.sz = s; x.sg = g; x.off = o; x.addr = a; x.alu = d;
    return x;
  endfunction

  // Reference extraction: pick an aligned field of nb bytes, then extend
  function automatic logic [DW-1:0] ref_ld(input logic [DW-1:0] rd, input logic [1:0] s,
                                           input logic g, input logic [OW-1:0] o);
    int nb, st;
    logic [63:0] v;
    nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : DW/8;
    st = (s == 2'd3) ? 0 : (int'(o) / nb) * nb;
    v  = (64'(rd) >> (8*st)) & ((64'd1 << (8*nb)) - 64'd1);
    if (g && v[8*nb-1]) v = v - (64'd1 << (8*nb));
    return v[DW-1:0];
  endfunction

  vec_t  vt [11];
  hent_t hq [$];
  ins_t  idle_i;
  ins_t  pend, cur;
  logic  busy, commit, e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data, cd;

  initial begin
    idle_i = mk(0, 0, 0, 0, 0, 0, 0);
    vt[0]  = '{mk(1, 0, 0, 0, 0, 5, 32'h1234_5678), 32'h0, 1, 5, 32'h1234_5678};
    vt[1]  = '{mk(1, 1, 0, 1, 2, 7, 0), 32'h0080_0000, 1, 7, 32'hFFFF_FF80};
    vt[2]  = '{mk(1, 1, 0, 0, 2, 7, 0), 32'h0080_0000, 1, 7, 32'h0000_0080};
    vt[3]  = '{mk(1, 1, 1, 1, 2, 8, 0), 32'hBEEF_0000, 1, 8, 32'hFFFF_BEEF};
    vt[4]  = '{mk(1, 1, 1, 0, 3, 8, 0), 32'hBEEF_0000, 1, 8, 32'h0000_BEEF};
    vt[5]  = '{mk(1, 1, 2, 1, 3, 9, 0), 32'h89AB_CDEF, 1, 9, 32'h89AB_CDEF};
    vt[6]  = '{mk(1, 1, 3, 1, 1, 10, 0), 32'h1357_9BDF, 1, 10, 32'h1357_9BDF};
    vt[7]  = '{mk(1, 1, 0, 1, 0, 11, 0), 32'h0000_007F, 1, 11, 32'h0000_007F};
    vt[8]  = '{mk(1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF), 32'h0, 0, 0, 0};
    vt[9]  = '{mk(0, 0, 0, 0, 0, 9, 32'h5555_5555), 32'h0, 0, 0, 0};
    vt[10] = '{mk(1, 1, 0, 0, 3, 12, 0), 32'hA500_0000, 1, 12, 32'h0000_00A5};

    rst = 1'b1;
    byp_addr = '0;
    put(idle_i, 0, 0, 0);
    tick;
    chk("rst_ready", ready, 1);
    chk("rst_wr", o_wr, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_data", o_data, 0);
    chk("rst_hit", byp_hit, 0);
    tick;
    rst = 1'b0;

    // Back-to-back table, one instruction per cycle
    for (int i = 0; i < 11; i++) begin
      put(vt[i].in, 1, vt[i].in.m2r, vt[i].rd);
      tick;
      chk($sformatf("vec%0d_wr", i), o_wr, vt[i].e_wr);
      chk($sformatf("vec%0d_ready", i), ready, 1);
      if (vt[i].e_wr) begin
        chk($sformatf("vec%0d_addr", i), o_addr, vt[i].e_addr);
        chk($sformatf("vec%0d_data", i), o_data, vt[i].e_data);
      end
    end
    put(idle_i, 0, 0, 0);
    tick;
    chk("strobe_drop", o_wr, 0);

    // Late half load; valid held high while waiting must be ignored
    put(mk(1, 1, 1, 0, 2, 10, 0), 1, 0, 32'hBEEF_0000);
    tick;
    put(mk(1, 0, 0, 0, 0, 6, 32'h0BAD_0BAD), 1, 0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("late_wait%0d_ready", c), ready, 0);
      chk($sformatf("late_wait%0d_wr", c), o_wr, 0);
      if (c < 2) tick;
    end
    put(idle_i, 0, 1, 32'hBEEF_0000);
    tick;
    chk("late_wr", o_wr, 1);
    chk("late_addr", o_addr, 10);
    chk("late_data", o_data, 32'h0000_BEEF);
    chk("late_ready", ready, 1);

    // Stray rvalid with nothing pending
    put(idle_i, 0, 1, 32'hFFFF_FFFF);
    tick;
    chk("stray_rvalid_wr", o_wr, 0);
    chk("stray_rvalid_data", o_data, 32'h0000_BEEF);

    // Bypass: newest match wins, ages out after HD other commits
    put(mk(1, 0, 0, 0, 0, 3, 32'hA), 1, 0, 0);
    tick;
    put(mk(1, 0, 0, 0, 0, 3, 32'hB), 1, 0, 0);
    tick;
    put(mk(1, 0, 0, 0, 0, 0, 32'hC), 1, 0, 0);
    tick;
    put(idle_i, 0, 0, 0);
    byp_addr = {5'd0, 5'd3};
    #1;
    chk("byp_r3_hit", byp_hit[0], BYP);
    chk("byp_r3_data", byp_data[DW-1:0], BYP ? 32'hB : 32'h0);
    chk("byp_r0_miss", byp_hit[1], 0);
    for (int i = 0; i < HD; i++) begin
      put(mk(1, 0, 0, 0, 0, AW'(20 + i), 32'h100 + 32'(i)), 1, 0, 0);
      tick;
    end
    put(idle_i, 0, 0, 0);
    byp_addr = {5'd20, 5'd3};
    #1;
    chk("byp_r3_aged", byp_hit[0], 0);
    chk("byp_r20_hit", byp_hit[1], BYP);

    // Randomized run against the reference model
    rst = 1'b1;
    put(idle_i, 0, 0, 0);
    tick;
    rst = 1'b0;
    busy = 0;
    pend = idle_i;
    hq.delete();
    e_addr = '0;
    e_data = '0;
    for (int n = 0; n < 400; n++) begin
      cur = mk($urandom_range(0, 9) != 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
               $urandom_range(0, 1), OW'($urandom_range(0, 3)), AW'($urandom_range(0, 7)),
               $urandom);
      put(cur, $urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom);
      commit = 0;
      cd = '0;
      if (!busy) begin
        if (valid) begin
          if (cur.m2r && !rvalid) begin
            busy = 1;
            pend = cur;
          end else begin
            commit = 1;
            pend = cur;
          end
        end
      end else if (rvalid) begin
        commit = 1;
        busy = 0;
      end
      e_wr = commit && pend.rw && pend.addr != 0;
      if (commit) begin
        cd = pend.m2r ? ref_ld(rdata, pend.sz, pend.sg, pend.off) : pend.alu;
        e_addr = pend.addr;
        e_data = cd;
      end
      if (e_wr) begin
        hq.push_front('{pend.addr, cd});
        if (hq.size() > HD) void'(hq.pop_back());
      end
      tick;
      chk("rnd_wr", o_wr, e_wr);
      chk("rnd_ready", ready, !busy);
      if (e_wr) begin
        chk("rnd_addr", o_addr, e_addr);
        chk("rnd_data", o_data, e_data);
      end
      byp_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      #1;
      for (int p = 0; p < NL; p++) begin
        logic          h;
        logic [DW-1:0] d;
        logic [AW-1:0] la;
        h  = 0;
        d  = '0;
        la = byp_addr[p*AW +: AW];
        if (BYP && la != 0) begin
          for (int k = hq.size() - 1; k >= 0; k--)
            if (hq[k].a == la) begin
              h = 1;
              d = hq[k].d;
            end
        end
        chk($sformatf("rnd_hit%0d", p), byp_hit[p], h);
        chk($sformatf("rnd_bdata%0d", p), byp_data[p*DW +: DW], d);
      end
    end

    // Reset while a late load is pending drops it
    rst = 1'b1;
    put(idle_i, 0, 0, 0);
    tick;
    rst = 1'b0;
    put(mk(1, 1, 2, 0, 0, 13, 0), 1, 0, 0);
    tick;
    chk("rstwait_pending", ready, 0);
    rst = 1'b1;
    put(idle_i, 0, 0, 0);
    tick;
    rst = 1'b0;
    put(idle_i, 0, 1, 32'h7777_7777);
    byp_addr = {5'd13, 5'd13};
    tick;
    chk("rstwait_wr", o_wr, 0);
    chk("rstwait_ready", ready, 1);
    chk("rstwait_addr", o_addr, 0);
    chk("rstwait_data", o_data, 0);
    chk("rstwait_hit", byp_hit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
